// File: rtl/ula_arbiter_if.sv
// Bundles the requester, ULA and response signals of the ULA arbiter.
// The slave modport is the arbiter; the master modport is everything around it.
interface ula_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [3:0]        req_op0;
    logic [DATA_W-1:0] req_a0;
    logic [DATA_W-1:0] req_b0;
    logic [3:0]        req_op1;
    logic [DATA_W-1:0] req_a1;
    logic [DATA_W-1:0] req_b1;

    logic [3:0]        ula_op;
    logic [DATA_W-1:0] ula_inA;
    logic [DATA_W-1:0] ula_inB;
    logic [DATA_W-1:0] ula_result;
    logic              ula_zero;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_illegal;

    modport slave (
        input  req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1,
        input  ula_result, ula_zero, rsp_ready,
        output req_ready, ula_op, ula_inA, ula_inB,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal
    );

    modport master (
        output req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1,
        output ula_result, ula_zero, rsp_ready,
        input  req_ready, ula_op, ula_inA, ula_inB,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal
    );
endinterface

// File: rtl/ula_arbiter.sv
// Round-robin share of one ULA between the core datapath (0) and the TBE/aux unit (1).
// One operation in flight: operands are held on the ULA for the op latency, then the result is returned.
module ula_arbiter #(
    parameter int DATA_W     = 32,
    parameter int DIV_CYCLES = 4,
    parameter int MUL_CYCLES = 2
) (
    input  logic          clock,
    input  logic          reset,
    ula_arbiter_if.slave  bus,
    output logic [1:0]    state_dbg
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never waits on ready, and a raised rsp_valid holds its payload until taken.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_IDLE    = 4'b1111;
    localparam logic [3:0] OP_MAX_LEG = 4'b1011;

    state_t     state;
    logic       last_grant;
    logic       id;
    logic [3:0] cnt;
    logic [1:0] grant;

    function automatic logic [3:0] lat_m1(input logic [3:0] op);
        case (op)
            4'b0000: return 4'(DIV_CYCLES - 1);
            4'b0001: return 4'(MUL_CYCLES - 1);
            default: return 4'd0;
        endcase
    endfunction

    always_comb begin
        grant = 2'b00;
        if (state == IDLE) begin
            case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign bus.req_ready = grant;
    assign state_dbg     = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            last_grant      <= 1'b1;
            id              <= 1'b0;
            cnt             <= 4'd0;
            bus.ula_op      <= OP_IDLE;
            bus.ula_inA     <= '0;
            bus.ula_inB     <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_result  <= '0;
            bus.rsp_zero    <= 1'b0;
            bus.rsp_id      <= 1'b0;
            bus.rsp_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant[0] && bus.req_valid[0]) begin
                        bus.ula_op  <= bus.req_op0;
                        bus.ula_inA <= bus.req_a0;
                        bus.ula_inB <= bus.req_b0;
                        last_grant  <= 1'b0;
                        id          <= 1'b0;
                        cnt         <= lat_m1(bus.req_op0);
                        state       <= EXEC;
                    end else if (grant[1] && bus.req_valid[1]) begin
                        bus.ula_op  <= bus.req_op1;
                        bus.ula_inA <= bus.req_a1;
                        bus.ula_inB <= bus.req_b1;
                        last_grant  <= 1'b1;
                        id          <= 1'b1;
                        cnt         <= lat_m1(bus.req_op1);
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        bus.rsp_result  <= bus.ula_result[DATA_W-1:0];
                        bus.rsp_zero    <= bus.ula_zero;
                        bus.rsp_illegal <= (bus.ula_op > OP_MAX_LEG);
                        bus.rsp_id      <= id;
                        bus.rsp_valid   <= 1'b1;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    // Parking the ULA on 1111 keeps its output at 0 between operations.
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.ula_op    <= OP_IDLE;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter with a small behavioural ULA attached to the ula_* side.
// Expected results are hand-computed constants carried through a result queue.
module tb_ula_arbiter;
    localparam int DATA_W = 32;

    logic       clock;
    logic       reset;
    logic [1:0] state_dbg;
    int         checks;
    int         failures;
    logic [DATA_W-1:0] exp_q[$];

    ula_arbiter_if #(.DATA_W(DATA_W)) bus ();

    ula_arbiter #(.DATA_W(DATA_W), .DIV_CYCLES(4), .MUL_CYCLES(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Behavioural ULA: 0000 div, 0001 mul, 0011 add, everything else 0.
    always_comb begin
        case (bus.ula_op)
            4'b0000: bus.ula_result = (bus.ula_inB == '0) ? '0 : bus.ula_inA / bus.ula_inB;
            4'b0001: bus.ula_result = bus.ula_inA * bus.ula_inB;
            4'b0011: bus.ula_result = bus.ula_inA + bus.ula_inB;
            default: bus.ula_result = '0;
        endcase
        bus.ula_zero = (bus.ula_result == '0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic drive_req(input int i, input logic [3:0] op,
                             input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (i == 0) begin
            bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b;
            bus.req_valid[0] = 1'b1;
        end else begin
            bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b;
            bus.req_valid[1] = 1'b1;
        end
    endtask

    // Expects the pending request(s) to grant exp_id, then follows that op to completion.
    task automatic run_txn(input logic exp_id, input logic [3:0] op,
                           input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input int lat, input logic [DATA_W-1:0] exp_res,
                           input logic exp_zero, input logic exp_ill, input int bp_cycles);
        int n;
        logic [DATA_W-1:0] held;
        n = 0;
        while (bus.req_ready == 2'b00 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (bus.req_ready == 2'b00) begin
            check("accept_timeout", 64'(n), 64'd0);
            bus.req_valid = 2'b00;
            return;
        end
        check("grant", 64'(bus.req_ready), (exp_id ? 64'd2 : 64'd1));
        exp_q.push_back(exp_res);
        @(negedge clock);
        bus.req_valid = 2'b00;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            check("hold_op", 64'(bus.ula_op), 64'(op));
            check("hold_a", 64'(bus.ula_inA), 64'(a));
            check("hold_b", 64'(bus.ula_inB), 64'(b));
            @(negedge clock);
            n++;
        end
        check("latency", 64'(n), 64'(lat));
        check("rsp_id", 64'(bus.rsp_id), 64'(exp_id));
        check("rsp_zero", 64'(bus.rsp_zero), 64'(exp_zero));
        check("rsp_illegal", 64'(bus.rsp_illegal), 64'(exp_ill));
        held = bus.rsp_result;
        if (exp_q.size() > 0) check("rsp_result", 64'(bus.rsp_result), 64'(exp_q.pop_front()));
        if (bp_cycles > 0) drive_req(0, 4'b0011, 32'd1, 32'd1);
        for (int k = 0; k < bp_cycles; k++) begin
            @(negedge clock);
            check("bp_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp_result", 64'(bus.rsp_result), 64'(held));
            check("bp_ready", 64'(bus.req_ready), 64'd0);
            check("bp_state", 64'(state_dbg), 64'd2);
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        check("rsp_drop", 64'(bus.rsp_valid), 64'd0);
        check("park_op", 64'(bus.ula_op), 64'hF);
        check("idle_state", 64'(state_dbg), 64'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_op0 = 4'h0; bus.req_a0 = '0; bus.req_b0 = '0;
        bus.req_op1 = 4'h0; bus.req_a1 = '0; bus.req_b1 = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_state", 64'(state_dbg), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
        check("rst_ula_op", 64'(bus.ula_op), 64'hF);
        check("rst_ula_a", 64'(bus.ula_inA), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Single add from requester 0
        drive_req(0, 4'b0011, 32'd5, 32'd7);
        run_txn(1'b0, 4'b0011, 32'd5, 32'd7, 1, 32'd12, 1'b0, 1'b0, 0);

        // Division from requester 1: 100/7
        drive_req(1, 4'b0000, 32'd100, 32'd7);
        run_txn(1'b1, 4'b0000, 32'd100, 32'd7, 4, 32'd14, 1'b0, 1'b0, 0);

        // Three contended rounds, last grant was 1 so order is 0,1,0
        drive_req(0, 4'b0001, 32'd6, 32'd7);
        drive_req(1, 4'b0011, 32'd10, 32'd20);
        run_txn(1'b0, 4'b0001, 32'd6, 32'd7, 2, 32'd42, 1'b0, 1'b0, 0);
        drive_req(0, 4'b0001, 32'd6, 32'd7);
        drive_req(1, 4'b0011, 32'd10, 32'd20);
        run_txn(1'b1, 4'b0011, 32'd10, 32'd20, 1, 32'd30, 1'b0, 1'b0, 0);
        drive_req(0, 4'b0001, 32'd6, 32'd7);
        drive_req(1, 4'b0011, 32'd10, 32'd20);
        run_txn(1'b0, 4'b0001, 32'd6, 32'd7, 2, 32'd42, 1'b0, 1'b0, 0);

        // Backpressure for 5 cycles with a competing request pending
        drive_req(1, 4'b0011, 32'hFFFF_FFFF, 32'd2);
        run_txn(1'b1, 4'b0011, 32'hFFFF_FFFF, 32'd2, 1, 32'd1, 1'b0, 1'b0, 5);

        // Zero result on a legal op, then an illegal op
        drive_req(0, 4'b0011, 32'd0, 32'd0);
        run_txn(1'b0, 4'b0011, 32'd0, 32'd0, 1, 32'd0, 1'b1, 1'b0, 0);
        drive_req(0, 4'b1110, 32'd3, 32'd3);
        run_txn(1'b0, 4'b1110, 32'd3, 32'd3, 1, 32'd0, 1'b1, 1'b1, 0);

        // Reset in the middle of a multiply
        drive_req(0, 4'b0001, 32'd6, 32'd7);
        @(negedge clock);
        bus.req_valid = 2'b00;
        check("mid_exec", 64'(state_dbg), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_rst_state", 64'(state_dbg), 64'd0);
        check("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
        check("mid_rst_op", 64'(bus.ula_op), 64'hF);
        check("mid_rst_a", 64'(bus.ula_inA), 64'd0);

        // Fresh contended request: requester 0 must win first after reset
        drive_req(0, 4'b0011, 32'd2, 32'd3);
        drive_req(1, 4'b0000, 32'd9, 32'd3);
        run_txn(1'b0, 4'b0011, 32'd2, 32'd3, 1, 32'd5, 1'b0, 1'b0, 0);
        drive_req(1, 4'b0000, 32'd9, 32'd3);
        run_txn(1'b1, 4'b0000, 32'd9, 32'd3, 4, 32'd3, 1'b0, 1'b0, 0);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
